// File: rtl/vga_pkg.sv
// vga_pkg: shared raster constants, FSM state encoding and colour types for
// the collenda VGA frame printer. Defaults give 640x480 @ 60 Hz from 50 MHz.
package vga_pkg;

  // Default raster timing (pixels / lines)
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int CLK_DIV_D  = 2;

  localparam int H_TOTAL_D = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    PRINTING = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Counter width able to hold 0..total (one spare code so that boundary
  // constants equal to the total never truncate).
  function automatic int cnt_w(input int total);
    return (total < 2) ? 1 : $clog2(total + 1);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel divider, horizontal/vertical raster counters, sync and
// video_on generation plus frame_start / last_pixel strobes.
// Optional VGA_BORDER_EN adds a border-pixel flag output.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int CLK_DIV  = CLK_DIV_D
) (
  input  logic clk,
  input  logic reset,
  output logic hsync_n,
  output logic vsync_n,
  output logic video_on,
  output logic frame_start,
  output logic last_pixel
`ifdef VGA_BORDER_EN
  ,
  output logic border
`endif
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = cnt_w(HT);
  localparam int VW = cnt_w(VT);
  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] div;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          tick;
  logic          h_last;
  logic          v_last;

  assign tick   = (div == DW'(CLK_DIV - 1));
  assign h_last = (h_cnt == HW'(HT - 1));
  assign v_last = (v_cnt == VW'(VT - 1));

  // Divider and raster counters; h/v only move on the pixel tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      div <= '0;
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end else begin
      div <= div + DW'(1);
    end
  end

  assign hsync_n = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                     (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_n = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                     (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign video_on = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));

  // frame_start fires on the tick that wraps the raster onto (0,0), so a
  // state change taken on it is already in effect for the whole first pixel.
  assign frame_start = tick && h_last && v_last;
  assign last_pixel  = tick && (h_cnt == HW'(H_ACTIVE - 1)) &&
                       (v_cnt == VW'(V_ACTIVE - 1));

`ifdef VGA_BORDER_EN
  assign border = (h_cnt == '0) || (h_cnt == HW'(H_ACTIVE - 1)) ||
                  (v_cnt == '0) || (v_cnt == VW'(V_ACTIVE - 1));
`endif

endmodule

// File: rtl/vga_frame_printer.sv
// vga_frame_printer: paints one full VGA frame in a latched colour per
// print request and flags completion. Raster timing lives in vga_timing.
// Optional VGA_BORDER_EN paints a white one-pixel border around the frame.
module vga_frame_printer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int CLK_DIV  = CLK_DIV_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color_r,
  input  logic [COLOR_W-1:0] color_g,
  input  logic [COLOR_W-1:0] color_b,
  input  logic               print_req,
  output logic               print_done,
  output logic               vga_hsync_n,
  output logic               vga_vsync_n,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  state_t state;
  rgb_t   latched;
  rgb_t   pix;
  logic   hsync_n;
  logic   vsync_n;
  logic   video_on;
  logic   frame_start;
  logic   last_pixel;
`ifdef VGA_BORDER_EN
  logic   border;
`endif

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .video_on    (video_on),
    .frame_start (frame_start),
    .last_pixel  (last_pixel)
`ifdef VGA_BORDER_EN
    ,
    .border      (border)
`endif
  );

  // Print FSM with colour latch and registered completion flag; dropping the
  // request before completion aborts straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      latched    <= '0;
      print_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (print_req) state <= ARMED;
        end
        ARMED: begin
          if (!print_req) begin
            state <= IDLE;
          end else if (frame_start) begin
            state   <= PRINTING;
            latched <= '{r: color_r, g: color_g, b: color_b};
          end
        end
        PRINTING: begin
          if (!print_req) begin
            state <= IDLE;
          end else if (last_pixel) begin
            state      <= DONE;
            print_done <= 1'b1;
          end
        end
        DONE: begin
          if (!print_req) begin
            state      <= IDLE;
            print_done <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          print_done <= 1'b0;
        end
      endcase
    end
  end

  // Pixel colour: latched colour only on visible pixels while printing
  always_comb begin
    pix = '0;
    if (video_on && (state == PRINTING)) begin
      pix = latched;
`ifdef VGA_BORDER_EN
      if (border) pix = '1;
`endif
    end
  end

  // Output register stage keeps sync and colour mutually aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hsync_n <= 1'b1;
      vga_vsync_n <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hsync_n <= hsync_n;
      vga_vsync_n <= vsync_n;
      vga_r       <= pix.r;
      vga_g       <= pix.g;
      vga_b       <= pix.b;
    end
  end

endmodule

// File: tb/tb_vga_frame_printer.sv
// tb_vga_frame_printer: randomized checks of vga_frame_printer on a shrunken
// raster against a cycle-index arithmetic model of the expected outputs.
module tb_vga_frame_printer;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int D  = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int F  = HT * VT * D;
  localparam int BIG = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cr = '0, cg = '0, cb = '0;
  logic       req = 1'b0;
  logic       print_done, hs_n, vs_n;
  logic [2:0] r_o, g_o, b_o;

  vga_frame_printer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(D)
  ) dut (
    .clk(clk), .reset(reset),
    .color_r(cr), .color_g(cg), .color_b(cb),
    .print_req(req), .print_done(print_done),
    .vga_hsync_n(hs_n), .vga_vsync_n(vs_n),
    .vga_r(r_o), .vga_g(g_o), .vga_b(b_o)
  );

  always #5 clk = ~clk;

  // clock edges since the last reset release
  int n;
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int vectors = 0;
  int errors  = 0;

  // model state: painted cycle window [s_paint, l_paint], done window
  int         s_paint = -1, l_paint = -2;
  int         done_from = -1, done_to = -1;
  logic [8:0] col = '0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
    logic       done;
  } obs_t;

  function automatic obs_t model(input int c);
    obs_t o;
    int k, p, h, v;
    o.hs = 1'b1; o.vs = 1'b1; o.rgb = '0;
    o.done = (c >= done_from) && (c < done_to);
    if (c > 0) begin
      k = c - 1; p = k / D; h = p % HT; v = (p / HT) % VT;
      o.hs = !(h >= HA + HF && h < HA + HF + HS);
      o.vs = !(v >= VA + VF && v < VA + VF + VS);
      if (h < HA && v < VA && k >= s_paint && k <= l_paint) begin
        o.rgb = col;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) o.rgb = 9'o777;
`endif
      end
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.hs = hs_n; o.vs = vs_n; o.rgb = {r_o, g_o, b_o}; o.done = print_done;
    return o;
  endfunction

  // first cycle in PRINTING for a request first driven during cycle r
  function automatic int start_of(input int r);
    return ((r + 2 + F - 1) / F) * F;
  endfunction

  function automatic int last_of(input int s);
    return s + ((VA - 1) * HT + HA - 1) * D + D - 1;
  endfunction

  task automatic test_reset();
    obs_t e, g;
    reset = 1'b1; req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset n=%0d got=%h want=%h", n, g, e);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_raster();
    obs_t e, g;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL idle_raster n=%0d got=%h want=%h", n, g, e);
      end
    end
  endtask

  task automatic test_print(input logic [8:0] c);
    obs_t e, g;
    int w, r, s, l;
    w = $urandom_range(0, F - 1);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL print_wait n=%0d got=%h want=%h", n, g, e);
      end
    end
    {cr, cg, cb} = c; col = c; req = 1'b1;
    r = n; s = start_of(r); l = last_of(s);
    s_paint = s; l_paint = l; done_from = l + 1; done_to = BIG;
    while (n < l + 4) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL print n=%0d got=%h want=%h", n, g, e);
      end
      if (n == s + F / 3) {cr, cg, cb} = 9'o111;
    end
    req = 1'b0; done_to = n + 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL print_release n=%0d got=%h want=%h", n, g, e);
      end
    end
  endtask

  // mode 0: drop the request mid-frame; mode 1: drop it while still armed
  task automatic test_abort(input int mode);
    obs_t e, g;
    int r, s, l, d;
    col = 9'($urandom_range(1, 511)); {cr, cg, cb} = col; req = 1'b1;
    r = n; s = start_of(r); l = last_of(s);
    if (mode == 0) d = s + ((VA / 2) * HT + $urandom_range(0, HT - 1)) * D;
    else           d = r + 1 + $urandom_range(0, s - r - 2);
    s_paint = s; l_paint = (d < l) ? d : l; done_from = -1; done_to = -1;
    while (n < s + F + 4) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort%0d n=%0d got=%h want=%h", mode, n, g, e);
      end
      if (n == d) req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    int r, s, l, d;
    col = 9'($urandom_range(0, 511)); {cr, cg, cb} = col; req = 1'b1;
    r = n; s = start_of(r); l = last_of(s);
    s_paint = s; l_paint = l; done_from = l + 1; done_to = BIG;
    d = l + 1 + $urandom_range(0, 5);
    while (n < d) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_first n=%0d got=%h want=%h", n, g, e);
      end
    end
    req = 1'b0; done_to = d + 1;
    @(negedge clk);
    e = model(n); g = sample(); vectors++;
    if (g !== e) begin
      errors++;
      $display("FAIL b2b_gap n=%0d got=%h want=%h", n, g, e);
    end
    col = 9'($urandom_range(0, 511)); {cr, cg, cb} = col; req = 1'b1;
    r = n; s = start_of(r); l = last_of(s);
    s_paint = s; l_paint = l; done_from = l + 1; done_to = BIG;
    while (n < l + 3) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_second n=%0d got=%h want=%h", n, g, e);
      end
    end
    req = 1'b0; done_to = n + 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_release n=%0d got=%h want=%h", n, g, e);
      end
    end
  endtask

  // reset at raster (5,3) while printing; hsync low must then start at
  // pixel HA+HF of the restarted raster
  task automatic test_reset_mid();
    obs_t e, g;
    int r, s, first;
    col = 9'o536; {cr, cg, cb} = col; req = 1'b1;
    r = n; s = start_of(r);
    s_paint = s; l_paint = last_of(s); done_from = -1; done_to = -1;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_mid_pre n=%0d got=%h want=%h", n, g, e);
      end
      if (n > s && (n / D) % HT == 5 && ((n / D) / HT) % VT == 3) break;
    end
    #2 reset = 1'b1; req = 1'b0;
    s_paint = -1; l_paint = -2;
    #1;
    g = sample(); vectors++;
    if (g !== {1'b1, 1'b1, 9'o000, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", g, {1'b1, 1'b1, 9'o000, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < HT * D + 5; i++) begin
      @(negedge clk);
      e = model(n); g = sample(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_mid_post n=%0d got=%h want=%h", n, g, e);
      end
      if (!hs_n && first < 0) first = n;
    end
    vectors++;
    if (first !== (HA + HF) * D + 1) begin
      errors++;
      $display("FAIL first_hsync got=%0d want=%0d", first, (HA + HF) * D + 1);
    end
  endtask

  initial begin
    test_reset();
    test_idle_raster();
    test_print(9'o536);
    test_print(9'($urandom_range(0, 511)));
`ifdef VGA_BORDER_EN
    test_print(9'o222);
`endif
    test_abort(0);
    test_abort(1);
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
